// File: rtl/sar_search.sv
// Binary-search initiator for the 4-bit magnitude comparator.
// SAR_SEARCH_ONEHOT_CHECK_EN enables abort on non-one-hot flag sets.
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] probe,
    input  logic             cmp_l,
    input  logic             cmp_e,
    input  logic             cmp_g,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] result,
    output logic [7:0]       steps,
    output logic             err
);

    typedef enum logic {IDLE, EVAL} state_t;

    localparam logic [WIDTH:0]   ONE     = (WIDTH+1)'(1);
    localparam logic [WIDTH:0]   HI_INIT = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] P_INIT  = {1'b0, {(WIDTH-1){1'b1}}};

    state_t           state_q;
    logic [WIDTH:0]   lo_q, hi_q;
    logic [WIDTH:0]   lo_d, hi_d;
    logic [WIDTH-1:0] probe_q, result_q;
    logic [WIDTH-1:0] mid_d;
    logic [WIDTH+1:0] sum_d;
    logic             busy_q, done_q, found_q;
    logic [7:0]       steps_q;
    logic             empty_d;
`ifdef SAR_SEARCH_ONEHOT_CHECK_EN
    logic             err_q;
    logic             bad_d;

    assign bad_d = !$onehot({cmp_l, cmp_e, cmp_g});
`endif

    // l wins over g; an all-zero flag set narrows like g
    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (cmp_l) lo_d = {1'b0, probe_q} + ONE;
        else       hi_d = {1'b0, probe_q} - ONE;
    end

    // hi is signed (may reach -1); lo is unsigned (may reach 2^WIDTH)
    assign empty_d = $signed({1'b0, lo_d}) > $signed({hi_d[WIDTH], hi_d});
    assign sum_d   = {1'b0, lo_d} + {1'b0, hi_d};
    assign mid_d   = WIDTH'(sum_d >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            probe_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            steps_q  <= '0;
`ifdef SAR_SEARCH_ONEHOT_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= EVAL;
                        lo_q     <= '0;
                        hi_q     <= HI_INIT;
                        probe_q  <= P_INIT;
                        result_q <= '0;
                        busy_q   <= 1'b1;
                        found_q  <= 1'b0;
                        steps_q  <= '0;
`ifdef SAR_SEARCH_ONEHOT_CHECK_EN
                        err_q    <= 1'b0;
`endif
                    end
                end
                EVAL: begin
                    steps_q <= steps_q + 8'd1;
`ifdef SAR_SEARCH_ONEHOT_CHECK_EN
                    if (bad_d) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else
`endif
                    if (cmp_e) begin
                        found_q  <= 1'b1;
                        result_q <= probe_q;
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        lo_q <= lo_d;
                        hi_q <= hi_d;
                        if (empty_d) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            probe_q <= mid_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign probe  = probe_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign found  = found_q;
    assign result = result_q;
    assign steps  = steps_q;
`ifdef SAR_SEARCH_ONEHOT_CHECK_EN
    assign err    = err_q;
`else
    assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: directed table, hand sequences
// and randomized searches against a behavioural binary-search model.
module tb_sar_search;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] probe;
    logic         cmp_l, cmp_e, cmp_g;
    logic         busy, done, found, err;
    logic [W-1:0] result;
    logic [7:0]   steps;

    // comparator behaviour: 0 honest, 1 stuck l, 2 l+g on first compare, 3 stuck g
    int mode;
    int tgt;
    int ncmp;
    int n_cmp = 0;
    int n_bad = 0;

    int exp_q[$];
    int exp_n, exp_found, exp_res, exp_err;

    sar_search #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .probe  (probe),
        .cmp_l  (cmp_l),
        .cmp_e  (cmp_e),
        .cmp_g  (cmp_g),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .result (result),
        .steps  (steps),
        .err    (err)
    );

    always #5 clk = ~clk;

    always_comb begin
        cmp_l = 1'b0;
        cmp_e = 1'b0;
        cmp_g = 1'b0;
        if (mode == 1) begin
            cmp_l = 1'b1;
        end else if (mode == 3) begin
            cmp_g = 1'b1;
        end else if (mode == 2 && ncmp == 0) begin
            cmp_l = 1'b1;
            cmp_g = 1'b1;
        end else begin
            cmp_l = int'(probe) < tgt;
            cmp_e = int'(probe) == tgt;
            cmp_g = int'(probe) > tgt;
        end
    end

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (mode %0d tgt %0d)",
                     nm, act, expv, mode, tgt);
        end
    endtask

    // Textbook binary search over integers, with the comparator behaviour
    function automatic void model(input int md, input int t);
        int lo, hi, p;
        bit l, e;
        lo = 0;
        hi = (1 << W) - 1;
        exp_q.delete();
        exp_n = 0;
        exp_found = 0;
        exp_res = 0;
        exp_err = 0;
        while (1) begin
            p = (lo + hi) / 2;
            exp_q.push_back(p);
            exp_n++;
            if (md == 2 && exp_n == 1) begin
`ifdef SAR_SEARCH_ONEHOT_CHECK_EN
                exp_err = 1;
                break;
`else
                l = 1'b1;
                e = 1'b0;
`endif
            end else if (md == 1) begin
                l = 1'b1;
                e = 1'b0;
            end else if (md == 3) begin
                l = 1'b0;
                e = 1'b0;
            end else begin
                l = p < t;
                e = p == t;
            end
            if (e) begin
                exp_found = 1;
                exp_res = p;
                break;
            end
            if (l) lo = p + 1;
            else   hi = p - 1;
            if (lo > hi) break;
        end
    endfunction

    task automatic run(input int md, input int t, input bit hold, input bit pre);
        int cyc;
        mode = md;
        tgt = t;
        ncmp = 0;
        model(md, t);
        if (!pre) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(negedge clk);
        if (!hold) start = 1'b0;
        chk("busy_after_start", busy, 1);
        cyc = 0;
        while (!done && cyc < 40) begin
            if (cyc < exp_q.size()) chk("probe", probe, exp_q[cyc]);
            @(negedge clk);
            cyc++;
            ncmp = cyc;
        end
        chk("done_seen", done, 1);
        chk("latency", cyc, exp_n);
        chk("steps", steps, exp_n);
        chk("found", found, exp_found);
        chk("result", result, exp_res);
        chk("err", err, exp_err);
        chk("busy_at_done", busy, 0);
        if (!hold) begin
            @(negedge clk);
            chk("done_pulse_end", done, 0);
        end
    endtask

    typedef struct {
        int md;
        int t;
        int f;
        int r;
        int s;
        int e;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{0, 11, 1, 11, 2, 0};
        vecs[1] = '{0, 0, 1, 0, 4, 0};
        vecs[2] = '{0, 15, 1, 15, 5, 0};
        vecs[3] = '{1, 5, 0, 0, 5, 0};
        vecs[4] = '{3, 5, 0, 0, 4, 0};
`ifdef SAR_SEARCH_ONEHOT_CHECK_EN
        vecs[5] = '{2, 11, 0, 0, 1, 1};
`else
        vecs[5] = '{2, 11, 1, 11, 2, 0};
`endif
        mode = 0;
        tgt = 0;
        ncmp = 0;
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_probe", probe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_result", result, 0);
        chk("rst_steps", steps, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run(vecs[i].md, vecs[i].t, 1'b0, 1'b0);
            chk("tbl_found", found, vecs[i].f);
            chk("tbl_result", result, vecs[i].r);
            chk("tbl_steps", steps, vecs[i].s);
            chk("tbl_err", err, vecs[i].e);
        end

        // start held through a search, then accepted in the done cycle
        run(0, 15, 1'b1, 1'b0);
        run(0, 6, 1'b0, 1'b1);

        // reset during the second compare cycle
        mode = 0;
        tgt = 15;
        ncmp = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        ncmp = 1;
        chk("pre_rst_probe", probe, 11);
        rst = 1'b1;
        #1;
        chk("mid_rst_probe", probe, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_steps", steps, 0);
        chk("mid_rst_found", found, 0);
        chk("mid_rst_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
        end

        for (int k = 0; k < 40; k++) begin
            run(int'($urandom_range(0, 3)), int'($urandom_range(0, (1 << W) - 1)),
                1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
